spi_flash_burn: RTL
===================

# spi_flash_burn

Flash-side responder for the burn sequence: it executes sector-erase and page-program requests issued by the burn trigger logic as real SPI NOR flash transactions. Each request becomes WREN, the erase or program command, and then status polling until the flash clears WIP. Completion, busy and error status are reported back to the requester. The block sits between the burn control logic and the configuration flash pins.

## Interface
- CLK_DIV, 2: CLK cycles per SCK half-period; legal range ≥1.
- PAGE_BYTES, 256: bytes sent per page program; legal range 1..256.
- CS_GAP, 4: minimum CLK cycles with CS_N high between transactions.
- POLL_MAX, 24'hffffff: maximum RDSR polls before timeout.
- CLK  in  1  system clock; every flop is clocked on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- SEC_ER  in  1  single-cycle pulse requesting a sector erase (opcode 0x20).
- PROG  in  1  single-cycle pulse requesting a page program (opcode 0x02).
- ADDR  in  24  flash byte address, sampled in the same cycle as the request.
- RD_EN  out  1  one-cycle read strobe for the next program byte.
- DIN  in  8  program byte; valid in the cycle after RD_EN.
- BUSY  out  1  high from the cycle after an accepted request until DONE.
- DONE  out  1  one-cycle pulse when the operation completes.
- ERR  out  1  one-cycle pulse on a rejected request or a poll timeout.
- SCK  out  1  SPI clock, mode 0 (idles low).
- CS_N  out  1  SPI chip select, active low.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.

## Operation
- States: IDLE, WREN, GAP1, CMD, DATA, GAP2, POLL, GAP3, FIN.
- IDLE: a request is accepted only when BUSY is low.
  - On SEC_ER, latch op=ERASE and ADDR; on PROG, latch op=PROGRAM and ADDR.
  - If SEC_ER and PROG arrive in the same cycle, SEC_ER wins and ERR pulses.
- A request that arrives while BUSY is high is ignored, and ERR pulses the next cycle.
- WREN: CS_N low, shift 0x06, CS_N high, then GAP1 for CS_GAP cycles.
- CMD: CS_N low, shift the opcode followed by ADDR[23:16], ADDR[15:8], ADDR[7:0].
  - For ERASE, raise CS_N after the last address byte and go to GAP2.
  - For PROGRAM, continue into DATA with CS_N still low.
- DATA: send PAGE_BYTES bytes, then CS_N high and go to GAP2.
  - RD_EN pulses in the first cycle of each preceding byte: the last address byte, or the previous data byte.
  - DIN is captured the following cycle into a holding register.
  - Exactly PAGE_BYTES RD_EN pulses are issued per operation.
- GAP2: CS_N high for CS_GAP cycles, then go to POLL.
- POLL: CS_N low, shift 0x05, then read one status byte, then CS_N high.
  - If bit0 (WIP) is 0, go to FIN.
  - Otherwise go to GAP3, wait CS_GAP cycles, and poll again.
  - The poll count is 24 bits. Reaching POLL_MAX polls causes ERR, then FIN.
- FIN: DONE pulses for one cycle and BUSY drops in the same cycle; the next state is IDLE.
- Reset at any point forces the following outputs immediately:
  - CS_N=1, SCK=0, MOSI=0.
  - BUSY=0, DONE=0, ERR=0, RD_EN=0.
  - state=IDLE, all counters 0.
  - No partial transaction is resumed after reset.

## Timing
- SCK toggles every CLK_DIV cycles, so one byte takes 16·CLK_DIV CLK cycles.
- Bit order is MSB first.
- MOSI changes on the SCK falling edge; the first bit is driven when CS_N falls.
- MISO is sampled in the CLK cycle in which SCK rises.
- CS_N falls 1 cycle after the request cycle, with BUSY rising in that same cycle.
- CS_N rises CLK_DIV cycles after the last SCK falling edge of a transaction.
- All outputs are registered. Each SCK period is symmetric.

## Structure
- Package spi_flash_pkg holds:
  - opcodes OP_WREN=8'h06, OP_SE=8'h20, OP_PP=8'h02, OP_RDSR=8'h05;
  - the state enum;
  - the op enum {ERASE, PROGRAM}.
- Sub-module spi_byte_shift handles one byte in mode 0.
  - It takes start and tx byte, and returns rx byte plus a done pulse.
  - It owns the SCK divider and the MOSI/MISO shifting.
- The top level holds the FSM, byte/poll counters, address/op latches and the RD_EN/DIN holding register.

## Test plan
All scenarios use CLK_DIV=2 and PAGE_BYTES=4.
- Erase at ADDR=24'h012000 with the flash model reporting WIP=1 for 3 polls → bus sequence 06 | 20 01 20 00 | 05 xx ×4, one DONE, 0 RD_EN pulses.
- Program at ADDR=24'h000100 with DIN source A0,A1,A2,A3 → bus sequence 06 | 02 00 01 00 A0 A1 A2 A3, exactly 4 RD_EN pulses, one DONE.
- PROG pulse while BUSY → ERR pulse one cycle later; bus traffic and DONE count are unchanged.
- SEC_ER and PROG in the same cycle → an erase is performed and ERR pulses once.
- POLL_MAX=3 with WIP stuck at 1 → exactly 3 RDSR transactions, ERR and DONE both pulse, then BUSY=0.
- RST asserted during a DATA byte → CS_N=1 and SCK=0 immediately; a new erase afterwards completes normally.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, status bits and FSM/op encodings for the SPI NOR burn responder.
package spi_flash_pkg;

   localparam logic [7:0] OP_WREN = 8'h06;
   localparam logic [7:0] OP_SE   = 8'h20;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_RDSR = 8'h05;
   localparam logic [7:0] SR_WIP  = 8'h01;

   typedef enum logic [3:0] {
      IDLE, WREN, GAP1, CMD, DATA, GAP2, POLL, GAP3, FIN
   } state_t;

   typedef enum logic {ERASE, PROGRAM} op_t;

endpackage

// File: rtl/spi_byte_shift.sv
// One mode-0 SPI byte: MSB-first on MOSI, MISO captured on each SCK rise.
module spi_byte_shift #(
   parameter int CLK_DIV = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic [7:0] tx,
   input  logic       miso,
   output logic [7:0] rx,
   output logic       done,
   output logic       sck,
   output logic       mosi
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   logic        active;
   logic [15:0] div;
   logic [3:0]  half;
   logic [6:0]  sh;
   logic        tick;

   assign tick = active && (div == DIV_LAST);
   // Combinational so a back-to-back byte can launch on the final falling edge.
   assign done = tick && (half == 4'd15);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         active <= 1'b0;
         div    <= '0;
         half   <= '0;
         sh     <= '0;
         rx     <= '0;
         sck    <= 1'b0;
         mosi   <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         div    <= '0;
         half   <= '0;
         sh     <= tx[6:0];
         mosi   <= tx[7];
         sck    <= 1'b0;
      end else if (active) begin
         if (tick) begin
            div  <= '0;
            half <= half + 4'd1;
            sck  <= ~sck;
            if (!sck) begin
               rx <= {rx[6:0], miso};
            end else if (half != 4'd15) begin
               mosi <= sh[6];
               sh   <= {sh[5:0], 1'b0};
            end
            if (half == 4'd15) active <= 1'b0;
         end else begin
            div <= div + 16'd1;
         end
      end
   end

endmodule

// File: rtl/spi_flash_burn.sv
// Turns erase/program requests into WREN, command and RDSR-poll SPI flash transactions.
module spi_flash_burn
   import spi_flash_pkg::*;
#(
   parameter int          CLK_DIV    = 2,
   parameter int          PAGE_BYTES = 256,
   parameter int          CS_GAP     = 4,
   parameter logic [23:0] POLL_MAX   = 24'hffffff
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SEC_ER,
   input  logic        PROG,
   input  logic [23:0] ADDR,
   output logic        RD_EN,
   input  logic [7:0]  DIN,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic        SCK,
   output logic        CS_N,
   output logic        MOSI,
   input  logic        MISO
);

   localparam logic [15:0] TAIL_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST  = 16'((CS_GAP > 0) ? CS_GAP - 1 : 0);
   localparam logic [8:0]  LAST_DATA = 9'(PAGE_BYTES - 1);

   state_t      state, state_n;
   op_t         op, op_n;
   logic [23:0] addr, addr_n, poll, poll_n;
   logic [15:0] cnt, cnt_n;
   logic [8:0]  byte_i, byte_n;
   logic        tail, tail_n;
   logic        cs_n_n, busy_n, done_n, err_n, rd_en_n;
   logic        rd_en_q;
   logic [7:0]  hold;
   logic        start, sh_done, req, wip;
   logic [7:0]  tx, rx;

   assign req = SEC_ER | PROG;
   assign wip = |(rx & SR_WIP);

   spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
      .CLK   (CLK),
      .RST   (RST),
      .start (start),
      .tx    (tx),
      .miso  (MISO),
      .rx    (rx),
      .done  (sh_done),
      .sck   (SCK),
      .mosi  (MOSI)
   );

   always_comb begin
      state_n = state;
      op_n    = op;
      addr_n  = addr;
      poll_n  = poll;
      cnt_n   = cnt;
      byte_n  = byte_i;
      tail_n  = tail;
      cs_n_n  = CS_N;
      busy_n  = BUSY;
      done_n  = 1'b0;
      err_n   = BUSY & req;
      rd_en_n = 1'b0;
      start   = 1'b0;
      tx      = '0;
      case (state)
         IDLE, FIN: begin
            state_n = IDLE;
            if (req) begin
               state_n = WREN;
               op_n    = SEC_ER ? ERASE : PROGRAM;
               addr_n  = ADDR;
               poll_n  = '0;
               byte_n  = '0;
               cnt_n   = '0;
               tail_n  = 1'b0;
               err_n   = SEC_ER & PROG;
               busy_n  = 1'b1;
               cs_n_n  = 1'b0;
               start   = 1'b1;
               tx      = OP_WREN;
            end
         end
         GAP1, GAP2, GAP3: begin
            if (cnt == GAP_LAST) begin
               cnt_n  = '0;
               byte_n = '0;
               cs_n_n = 1'b0;
               start  = 1'b1;
               if (state == GAP1) begin
                  state_n = CMD;
                  tx      = (op == ERASE) ? OP_SE : OP_PP;
               end else begin
                  state_n = POLL;
                  tx      = OP_RDSR;
               end
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: begin
            // tail holds CS_N low for one SCK half-period after the last falling edge
            if (tail) begin
               if (cnt == TAIL_LAST) begin
                  cs_n_n = 1'b1;
                  tail_n = 1'b0;
                  cnt_n  = '0;
                  case (state)
                     WREN: state_n = GAP1;
                     POLL: begin
                        if (wip && (poll < POLL_MAX)) begin
                           state_n = GAP3;
                        end else begin
                           state_n = FIN;
                           done_n  = 1'b1;
                           busy_n  = 1'b0;
                        end
                     end
                     default: state_n = GAP2;
                  endcase
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end else if (sh_done) begin
               byte_n = byte_i + 9'd1;
               cnt_n  = '0;
               case (state)
                  WREN: tail_n = 1'b1;
                  CMD: begin
                     if (byte_i < 9'd3) begin
                        start = 1'b1;
                        case (byte_i[1:0])
                           2'd0:    tx = addr[23:16];
                           2'd1:    tx = addr[15:8];
                           default: tx = addr[7:0];
                        endcase
                        rd_en_n = (op == PROGRAM) && (byte_i == 9'd2);
                     end else if (op == ERASE) begin
                        tail_n = 1'b1;
                     end else begin
                        state_n = DATA;
                        byte_n  = '0;
                        start   = 1'b1;
                        tx      = hold;
                        rd_en_n = (LAST_DATA != 9'd0);
                     end
                  end
                  DATA: begin
                     if (byte_i == LAST_DATA) begin
                        tail_n = 1'b1;
                     end else begin
                        start   = 1'b1;
                        tx      = hold;
                        rd_en_n = (byte_n < LAST_DATA);
                     end
                  end
                  POLL: begin
                     if (byte_i == 9'd0) begin
                        start = 1'b1;
                        tx    = 8'h00;
                     end else begin
                        tail_n = 1'b1;
                        if (wip) begin
                           poll_n = poll + 24'd1;
                           if (poll + 24'd1 >= POLL_MAX) err_n = 1'b1;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         op      <= ERASE;
         addr    <= '0;
         poll    <= '0;
         cnt     <= '0;
         byte_i  <= '0;
         tail    <= 1'b0;
         CS_N    <= 1'b1;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         RD_EN   <= 1'b0;
         rd_en_q <= 1'b0;
         hold    <= '0;
      end else begin
         state   <= state_n;
         op      <= op_n;
         addr    <= addr_n;
         poll    <= poll_n;
         cnt     <= cnt_n;
         byte_i  <= byte_n;
         tail    <= tail_n;
         CS_N    <= cs_n_n;
         BUSY    <= busy_n;
         DONE    <= done_n;
         ERR     <= err_n;
         RD_EN   <= rd_en_n;
         rd_en_q <= RD_EN;
         if (rd_en_q) hold <= DIN;
      end
   end

endmodule
